// File: rtl/keccak_arbiter.sv
// Round-robin arbiter sharing one Keccak core between NREQ requesters.
// Each grant passes through a one-cycle core flush before routing begins.
module keccak_arbiter #(
  parameter int NREQ = 3,
  parameter int W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_i,
  output logic [NREQ-1:0]   gnt_o,
  input  logic [NREQ-1:0]   rst_k_i,
  input  logic [NREQ*W-1:0] din_i,
  input  logic [NREQ-1:0]   src_ready_i,
  input  logic [NREQ-1:0]   dst_ready_i,
  output logic [NREQ-1:0]   src_read_o,
  output logic [NREQ-1:0]   dst_write_o,
  output logic [W-1:0]      dout_o,
  output logic              rst_k_o,
  output logic [W-1:0]      din_o,
  input  logic [W-1:0]      dout_i,
  output logic              src_ready_o,
  input  logic              src_read_i,
  input  logic              dst_write_i,
  output logic              dst_ready_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_BUSY} state_t;

  state_t            state_reg, state_next;
  logic [NREQ-1:0]   gnt_reg, gnt_next;
  logic [PW-1:0]     rr_ptr_reg, rr_ptr_next;

  logic [2*NREQ-1:0] req_dbl, rot_dbl;
  logic [NREQ-1:0]   req_rot, low_rot, pick;
  logic [PW-1:0]     g_idx, g_inc;
  logic              own_req, busy;
  logic [W-1:0]      din_masked [NREQ];
  logic [W-1:0]      din_sel;

  // Rotate requests so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
  assign req_dbl = {req_i, req_i};
  assign req_rot = req_dbl[NREQ-1:0] >> 0 == '0 ? '0 : NREQ'(req_dbl >> rr_ptr_reg);
  assign low_rot = req_rot & (~req_rot + ONE);
  assign rot_dbl = {low_rot, low_rot} << rr_ptr_reg;
  assign pick    = rot_dbl[2*NREQ-1:NREQ];

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_reg[i]) g_idx = PW'(i);
    end
  end

  assign g_inc   = (g_idx == PW'(NREQ - 1)) ? '0 : g_idx + PW'(1);
  assign own_req = |(req_i & gnt_reg);
  assign busy    = (state_reg == S_BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      gnt_reg    <= '0;
      rr_ptr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      gnt_reg    <= gnt_next;
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    gnt_next    = gnt_reg;
    rr_ptr_next = rr_ptr_reg;
    case (state_reg)
      S_IDLE: begin
        if (|req_i) begin
          gnt_next   = pick;
          state_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (own_req) begin
          state_next = S_BUSY;
        end else begin
          state_next = S_IDLE;
          gnt_next   = '0;
        end
      end
      S_BUSY: begin
        if (!own_req) begin
          state_next  = S_IDLE;
          gnt_next    = '0;
          rr_ptr_next = g_inc;
        end
      end
      default: begin
        state_next = S_IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_din
      assign din_masked[gi] = din_i[gi*W +: W] & {W{gnt_reg[gi]}};
    end
  endgenerate

  always_comb begin
    din_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      din_sel = din_sel | din_masked[i];
    end
  end

  // Core side is held idle (reset asserted, nothing ready) unless a transfer is routed.
  always_comb begin
    rst_k_o     = 1'b1;
    din_o       = '0;
    src_ready_o = 1'b1;
    dst_ready_o = 1'b1;
    src_read_o  = '0;
    dst_write_o = '0;
    if (busy) begin
      rst_k_o     = |(rst_k_i & gnt_reg);
      din_o       = din_sel;
      src_ready_o = |(src_ready_i & gnt_reg);
      dst_ready_o = |(dst_ready_i & gnt_reg);
      src_read_o  = gnt_reg & {NREQ{src_read_i}};
      dst_write_o = gnt_reg & {NREQ{dst_write_i}};
    end
  end

  assign gnt_o  = gnt_reg;
  assign dout_o = dout_i;

endmodule

// File: tb/tb_keccak_arbiter.sv
// Directed bench for keccak_arbiter: stimulus queues expected grants and
// transfers; a monitor compares them whenever the DUT presents one.
module tb_keccak_arbiter;

  localparam int NREQ = 3;
  localparam int W    = 64;

  typedef struct packed {
    logic [NREQ-1:0] rd;
    logic [NREQ-1:0] wr;
    logic [W-1:0]    din;
  } xfer_t;

  logic              clk, rst;
  logic [NREQ-1:0]   req_i, gnt_o, rst_k_i, src_ready_i, dst_ready_i;
  logic [NREQ-1:0]   src_read_o, dst_write_o;
  logic [NREQ*W-1:0] din_i;
  logic [W-1:0]      dout_o, din_o, dout_i;
  logic              rst_k_o, src_ready_o, src_read_i, dst_write_i, dst_ready_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [NREQ-1:0] exp_gnt[$];
  xfer_t           exp_xfer[$];

  keccak_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .gnt_o(gnt_o), .rst_k_i(rst_k_i),
    .din_i(din_i), .src_ready_i(src_ready_i), .dst_ready_i(dst_ready_i),
    .src_read_o(src_read_o), .dst_write_o(dst_write_o), .dout_o(dout_o),
    .rst_k_o(rst_k_o), .din_o(din_o), .dout_i(dout_i), .src_ready_o(src_ready_o),
    .src_read_i(src_read_i), .dst_write_i(dst_write_i), .dst_ready_o(dst_ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h at %0t", name, act, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] din_of(input int k);
    case (k)
      0:       din_of = 64'h1111_1111_1111_1111;
      1:       din_of = 64'h2222_2222_2222_2222;
      default: din_of = 64'h3333_3333_3333_3333;
    endcase
  endfunction

  // Monitor: a new non-zero grant or any requester-side strobe pops the scoreboard.
  initial begin
    logic [NREQ-1:0] prev_gnt;
    xfer_t           e;
    prev_gnt = '0;
    forever begin
      @(negedge clk);
      if (gnt_o !== prev_gnt && gnt_o !== '0) begin
        if (exp_gnt.size() == 0) chk("grant_unexpected", 64'(gnt_o), 64'd0);
        else chk("grant_order", 64'(gnt_o), 64'(exp_gnt.pop_front()));
      end
      prev_gnt = gnt_o;
      if (src_read_o !== '0 || dst_write_o !== '0) begin
        if (exp_xfer.size() == 0) begin
          chk("xfer_unexpected", {58'd0, src_read_o, dst_write_o}, 64'd0);
        end else begin
          e = exp_xfer.pop_front();
          chk("xfer_src_read", 64'(src_read_o), 64'(e.rd));
          chk("xfer_dst_write", 64'(dst_write_o), 64'(e.wr));
          chk("xfer_din", din_o, e.din);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] oh;
    int o;
    rst = 1'b1; req_i = '0; rst_k_i = 3'b110; src_ready_i = 3'b010; dst_ready_i = 3'b101;
    for (int k = 0; k < NREQ; k++) din_i[k*W +: W] = din_of(k);
    dout_i = 64'hFEED_FACE_0123_4567; src_read_i = 1'b0; dst_write_i = 1'b0;
    tick; tick;
    chk("rst_gnt", 64'(gnt_o), 64'd0);
    chk("rst_rst_k", 64'(rst_k_o), 64'd1);
    chk("rst_src_ready", 64'(src_ready_o), 64'd1);
    chk("rst_dst_ready", 64'(dst_ready_o), 64'd1);
    chk("rst_din", din_o, 64'd0);
    chk("dout_bcast", dout_o, 64'hFEED_FACE_0123_4567);
    rst = 1'b0;
    tick;

    // Stray core strobes in idle.
    src_read_i = 1'b1; dst_write_i = 1'b1; #1;
    chk("stray_dst_write", 64'(dst_write_o), 64'd0);
    chk("stray_src_read", 64'(src_read_o), 64'd0);
    tick; src_read_i = 1'b0; dst_write_i = 1'b0;

    // Single request.
    req_i = 3'b001; exp_gnt.push_back(3'b001);
    tick;
    chk("single_gnt", 64'(gnt_o), 64'd1);
    chk("flush_rst_k", 64'(rst_k_o), 64'd1);
    chk("flush_din", din_o, 64'd0);
    tick;
    chk("busy_din", din_o, din_of(0));
    chk("busy_rst_k", 64'(rst_k_o), 64'd0);
    chk("busy_src_ready", 64'(src_ready_o), 64'd0);
    chk("busy_dst_ready", 64'(dst_ready_o), 64'd1);
    exp_xfer.push_back('{rd: 3'b001, wr: 3'b001, din: din_of(0)});
    src_read_i = 1'b1; dst_write_i = 1'b1;
    tick;
    src_read_i = 1'b0; dst_write_i = 1'b0; req_i = '0;
    tick;
    chk("release_gnt", 64'(gnt_o), 64'd0);
    chk("release_rst_k", 64'(rst_k_o), 64'd1);

    rst = 1'b1; tick; rst = 1'b0; tick;

    // Round robin with all requesters asserted.
    req_i = 3'b111;
    for (int k = 0; k < 4; k++) begin
      o = k % NREQ;
      oh = 3'(1 << o);
      exp_gnt.push_back(oh);
      tick;
      chk("rr_gnt", 64'(gnt_o), 64'(oh));
      tick;
      exp_xfer.push_back('{rd: oh, wr: oh, din: din_of(o)});
      src_read_i = 1'b1; dst_write_i = 1'b1;
      tick;
      src_read_i = 1'b0; dst_write_i = 1'b0;
      tick; tick;
      req_i[o] = 1'b0;
      tick;
      chk("rr_idle_gnt", 64'(gnt_o), 64'd0);
      req_i = 3'b111;
    end
    req_i = '0;
    tick;

    // No preemption.
    req_i = 3'b001; exp_gnt.push_back(3'b001);
    tick;
    chk("np_gnt", 64'(gnt_o), 64'd1);
    tick;
    req_i = 3'b101;
    tick; chk("np_hold1", 64'(gnt_o), 64'd1);
    tick; chk("np_hold2", 64'(gnt_o), 64'd1);
    req_i = 3'b100;
    tick; chk("np_idle", 64'(gnt_o), 64'd0);
    exp_gnt.push_back(3'b100);
    tick; chk("np_next_gnt", 64'(gnt_o), 64'd4);
    tick;
    chk("np_busy_din", din_o, din_of(2));
    chk("np_busy_rst_k", 64'(rst_k_o), 64'd1);
    req_i = '0;
    tick; tick;

    // Abort during flush.
    req_i = 3'b010; exp_gnt.push_back(3'b010);
    tick;
    chk("abort_gnt", 64'(gnt_o), 64'd2);
    req_i = '0; src_read_i = 1'b1; dst_write_i = 1'b1; #1;
    chk("abort_src_read", 64'(src_read_o), 64'd0);
    chk("abort_dst_write", 64'(dst_write_o), 64'd0);
    tick;
    src_read_i = 1'b0; dst_write_i = 1'b0;
    chk("abort_idle_gnt", 64'(gnt_o), 64'd0);
    tick;
    chk("abort_stay_idle", 64'(gnt_o), 64'd0);

    // Move rr_ptr off zero, then reset asynchronously mid-transfer.
    req_i = 3'b010; exp_gnt.push_back(3'b010);
    tick; tick;
    req_i = '0;
    tick;
    req_i = 3'b100; exp_gnt.push_back(3'b100);
    tick; tick;
    chk("pre_async_din", din_o, din_of(2));
    #2 rst = 1'b1;
    #1;
    chk("async_gnt", 64'(gnt_o), 64'd0);
    chk("async_rst_k", 64'(rst_k_o), 64'd1);
    chk("async_din", din_o, 64'd0);
    req_i = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    req_i = 3'b110; exp_gnt.push_back(3'b010);
    tick;
    chk("post_rst_gnt", 64'(gnt_o), 64'd2);
    tick;
    req_i = '0;
    tick; tick; tick;

    chk("gnt_queue_drained", 64'(exp_gnt.size()), 64'd0);
    chk("xfer_queue_drained", 64'(exp_xfer.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keccak_arbiter.md
KECCAK_ARBITER -- requirements
Module: keccak_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 3: number of requesters sharing one Keccak core (2..8).
REQ-002 The block SHALL have parameter W, default 64: Keccak data word width.
REQ-003 The block SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 The block SHALL have port req_i, input, NREQ: per-requester hold-for-use request.
REQ-006 The block SHALL have port gnt_o, output, NREQ: one-hot registered grant.
REQ-007 The block SHALL have port rst_k_i, input, NREQ: per-requester Keccak reset request.
REQ-008 The block SHALL have port din_i, input, NREQ*W: per-requester data, slice k at [k*W+:W].
REQ-009 The block SHALL have port src_ready_i, input, NREQ: per-requester source flag, low = data available.
REQ-010 The block SHALL have port dst_ready_i, input, NREQ: per-requester sink flag, low = can accept.
REQ-011 The block SHALL have port src_read_o, output, NREQ: core consumed din of the granted requester.
REQ-012 The block SHALL have port dst_write_o, output, NREQ: core dout valid for the granted requester.
REQ-013 The block SHALL have port dout_o, output, W: core dout broadcast to all requesters.
REQ-014 The block SHALL have core-side ports rst_k_o (out, 1), din_o (out, W), dout_i (in, W), src_ready_o (out, 1), src_read_i (in, 1), dst_write_i (in, 1) and dst_ready_o (out, 1), with the same polarities as the requester side.

Function
REQ-015 The FSM SHALL have the states S_IDLE, S_FLUSH and S_BUSY, held in a registered state plus a registered one-hot grant.
REQ-016 In S_IDLE, when any req_i bit is set, the block SHALL select the first set bit at or after rr_ptr (round-robin, wrapping NREQ-1 to 0), load gnt_o and go to S_FLUSH.
REQ-017 S_FLUSH SHALL last exactly one cycle with rst_k_o=1 to clear the core.
- Next state is S_BUSY if the granted req_i is still set.
- Otherwise next state is S_IDLE with gnt_o cleared.
REQ-018 In S_BUSY, the block SHALL route the granted requester's rst_k_i, din_i slice, src_ready_i and dst_ready_i to the core outputs.
- src_read_i goes to src_read_o[g] and dst_write_i goes to dst_write_o[g].
- All other src_read_o and dst_write_o bits SHALL be 0.
REQ-019 In S_BUSY, when the granted req_i falls, the block SHALL go to S_IDLE, clear gnt_o and set rr_ptr to (g+1) mod NREQ.
- The core outputs SHALL still be routed during that cycle.
REQ-020 In S_IDLE and S_FLUSH, the core outputs SHALL be idle: src_ready_o=1, dst_ready_o=1, din_o=0 and all src_read_o/dst_write_o bits 0.
- rst_k_o SHALL be 1 in S_IDLE.
REQ-021 The block SHALL NOT preempt a grant: other requests are ignored until release.
REQ-022 Re-arbitration after a release SHALL take one S_IDLE cycle, then one S_FLUSH cycle.
- Handover latency from req drop to the new requester's first routed cycle is 3 clocks.
REQ-023 From S_IDLE, request-to-gnt_o latency SHALL be 1 clock, and the requester SHALL see routing 2 clocks after the request is sampled.
REQ-024 If src_read_i or dst_write_i pulses outside S_BUSY, the block SHALL discard it and SHALL NOT forward it to any requester.
REQ-025 Core outputs SHALL be combinational from state, grant and requester inputs; dout_o SHALL equal dout_i at all times.

Reset
REQ-026 On rst, the block SHALL immediately (asynchronously) set state S_IDLE, gnt_o=0 and rr_ptr=0.
- Outputs SHALL then take the S_IDLE values: rst_k_o=1, src_ready_o=1, dst_ready_o=1, din_o=0, src_read_o=0, dst_write_o=0.
REQ-027 Reset mid-S_BUSY SHALL abandon the transfer; after release, arbitration SHALL restart from rr_ptr=0.

Verification
REQ-028 Single request: req_i=001 at cycle 0 -> gnt_o=001 at cycle 1, rst_k_o=1 in cycle 1, then din_o=din_i[63:0] and src_read_i copied to src_read_o[0] from cycle 2.
REQ-029 Round-robin: req_i=111 held, each owner drops req for one cycle after 4 busy cycles -> grant order 001, 010, 100, 001.
REQ-030 No preemption: requester 0 busy and req_i[2] rises -> gnt_o stays 001 until req_i[0]=0, then 100 follows 2 cycles later.
REQ-031 Abort in flush: req_i[1] pulses for 1 cycle -> gnt_o=010 for one cycle, return to S_IDLE, no src_read_o/dst_write_o pulses.
REQ-032 Async reset: rst asserted mid-S_BUSY between clock edges -> gnt_o=0 and rst_k_o=1 before the next edge; afterwards req_i=110 grants 010 first.
REQ-033 Stray strobes: dst_write_i=1 while in S_IDLE -> dst_write_o=000.
